// File: rtl/uc_arbiter_rr.sv
// Unit-clause arbiter with round-robin engine grant and a broadcast FIFO.
// Initial unit literals are loaded from memory, then implied literals are
// collected from NUM_ENG BCP engines. Each accepted literal is checked against
// a per-variable polarity table: duplicates are dropped and an opposite
// polarity raises a sticky conflict.
// Optional: define UCA_STATS_EN to add saturating push/dup/stall counters.
module uc_arbiter_rr #(
    parameter int unsigned NUM_ENG = 4,
    parameter int unsigned LIT_W   = 8,
    parameter int unsigned Q_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       mem_valid,
    input  logic [LIT_W-1:0]           mem_lit,
    input  logic                       mem_done,
    output logic                       mem_ready,
    input  logic [NUM_ENG-1:0]         eng_valid,
    input  logic [NUM_ENG*LIT_W-1:0]   eng_lit,
    output logic [NUM_ENG-1:0]         eng_ready,
    output logic                       bcast_valid,
    output logic [LIT_W-1:0]           bcast_lit,
    input  logic                       bcast_ready,
    output logic                       conflict,
    output logic [LIT_W-2:0]           conflict_var,
    output logic [$clog2(Q_DEPTH):0]   q_count
`ifdef UCA_STATS_EN
    ,
    output logic [15:0]                stat_push,
    output logic [15:0]                stat_dup,
    output logic [15:0]                stat_stall
`endif
);

    localparam int unsigned VAR_W = LIT_W - 1;
    localparam int unsigned TBL_N = 2 ** VAR_W;
    localparam int unsigned AW    = $clog2(Q_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned EW    = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    typedef enum logic [1:0] {StLoad, StRun, StConflict} state_e;

    state_e           state_q, state_d;
    logic [LIT_W-1:0] fifo_mem [Q_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [EW-1:0]    rr_ptr_q, rr_ptr_d, gnt_idx, cand;
    logic             gnt_found;
    logic [TBL_N-1:0] pos_q, neg_q;
    logic [VAR_W-1:0] conf_var_q;

    logic             full, pop, can_accept;
    logic             acc_valid, acc_neg, lit_ok, same_seen, opp_seen;
    logic             lit_dup, lit_conf, push;
    logic [LIT_W-1:0] acc_lit, abs_lit;
    logic [VAR_W-1:0] acc_var;

    assign full        = (count_q == CW'(Q_DEPTH));
    assign bcast_valid = (count_q != '0) && (state_q != StConflict);
    assign pop         = bcast_valid && bcast_ready;
    // A pop in the same cycle frees a slot, so a full FIFO may still take a grant.
    assign can_accept  = !full || pop;
    assign bcast_lit   = bcast_valid ? fifo_mem[rd_ptr_q] : '0;
    assign conflict    = (state_q == StConflict);
    assign conflict_var = conf_var_q;
    assign q_count     = count_q;

    // Find the first requesting engine at or after the round-robin pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_ENG; k++) begin
            cand = EW'((32'(rr_ptr_q) + k) % NUM_ENG);
            if (!gnt_found && eng_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Source selection: memory in LOAD, granted engine in RUN; clear blocks consumption.
    always_comb begin
        mem_ready = 1'b0;
        eng_ready = '0;
        acc_valid = 1'b0;
        acc_lit   = mem_lit;
        rr_ptr_d  = rr_ptr_q;
        unique case (state_q)
            StLoad: begin
                mem_ready = !full && !clear;
                acc_valid = mem_valid && mem_ready;
            end
            StRun: begin
                if (gnt_found && can_accept && !clear) begin
                    eng_ready[gnt_idx] = 1'b1;
                    acc_valid          = 1'b1;
                    acc_lit            = eng_lit[32'(gnt_idx)*LIT_W +: LIT_W];
                    rr_ptr_d = (gnt_idx == EW'(NUM_ENG - 1)) ? '0 : gnt_idx + EW'(1);
                end
            end
            default: ;
        endcase
        if (clear) begin
            rr_ptr_d = '0;
        end
    end

    // Literal check against the polarity table. Variable index 0 is dropped.
    assign acc_neg   = acc_lit[LIT_W-1];
    assign abs_lit   = acc_neg ? (~acc_lit + LIT_W'(1)) : acc_lit;
    assign acc_var   = abs_lit[VAR_W-1:0];
    assign same_seen = acc_neg ? neg_q[acc_var] : pos_q[acc_var];
    assign opp_seen  = acc_neg ? pos_q[acc_var] : neg_q[acc_var];
    assign lit_ok    = acc_valid && (acc_var != '0) && !clear;
    assign lit_dup   = lit_ok && same_seen;
    assign lit_conf  = lit_ok && !same_seen && opp_seen;
    assign push      = lit_ok && !same_seen && !opp_seen;

    // Next state: clear wins over conflict, conflict wins over the LOAD exit.
    always_comb begin
        state_d = state_q;
        if ((state_q == StLoad) && mem_done) begin
            state_d = StRun;
        end
        if (lit_conf) begin
            state_d = StConflict;
        end
        if (clear) begin
            state_d = StLoad;
        end
    end

    // Control state, FIFO pointers, polarity table and conflict capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StLoad;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pos_q      <= '0;
            neg_q      <= '0;
            conf_var_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (clear || lit_conf) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
            if (clear) begin
                pos_q <= '0;
                neg_q <= '0;
            end else if (push) begin
                if (acc_neg) neg_q[acc_var] <= 1'b1;
                else         pos_q[acc_var] <= 1'b1;
            end
            if (clear)         conf_var_q <= '0;
            else if (lit_conf) conf_var_q <= acc_var;
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= acc_lit;
    end

`ifdef UCA_STATS_EN
    logic stall;
    assign stall = (state_q == StRun) && (|eng_valid) && !can_accept && !clear;

    // Saturating event counters, restarted by clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_push  <= '0;
            stat_dup   <= '0;
            stat_stall <= '0;
        end else if (clear) begin
            stat_push  <= '0;
            stat_dup   <= '0;
            stat_stall <= '0;
        end else begin
            if (push && (stat_push != 16'hFFFF))     stat_push  <= stat_push + 16'd1;
            if (lit_dup && (stat_dup != 16'hFFFF))   stat_dup   <= stat_dup + 16'd1;
            if (stall && (stat_stall != 16'hFFFF))   stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uc_arbiter_rr.sv
// Directed bench for uc_arbiter_rr with hand-computed expectations.
// Build with UCA_STATS_EN defined to also check the statistics counters.
module tb_uc_arbiter_rr;

    logic        clk = 1'b0;
    logic        rst, clear, mem_valid, mem_done, bcast_ready;
    logic [7:0]  mem_lit;
    logic [3:0]  eng_valid;
    logic [31:0] eng_lit;
    logic        mem_ready, bcast_valid, conflict;
    logic [3:0]  eng_ready;
    logic [7:0]  bcast_lit;
    logic [6:0]  conflict_var;
    logic [4:0]  q_count;
`ifdef UCA_STATS_EN
    logic [15:0] stat_push, stat_dup, stat_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Expected grants / broadcast head for the round-robin sequence.
    logic [3:0] rr_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000};
    logic       bv_exp [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] bl_exp [6] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd6, 8'd0};

    uc_arbiter_rr #(
        .NUM_ENG (4),
        .LIT_W   (8),
        .Q_DEPTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .mem_valid    (mem_valid),
        .mem_lit      (mem_lit),
        .mem_done     (mem_done),
        .mem_ready    (mem_ready),
        .eng_valid    (eng_valid),
        .eng_lit      (eng_lit),
        .eng_ready    (eng_ready),
        .bcast_valid  (bcast_valid),
        .bcast_lit    (bcast_lit),
        .bcast_ready  (bcast_ready),
        .conflict     (conflict),
        .conflict_var (conflict_var),
        .q_count      (q_count)
`ifdef UCA_STATS_EN
        ,
        .stat_push    (stat_push),
        .stat_dup     (stat_dup),
        .stat_stall   (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; clear = 1'b0; mem_valid = 1'b0; mem_lit = '0; mem_done = 1'b0;
        eng_valid = '0; eng_lit = '0; bcast_ready = 1'b0;
        #3;
        check_eq("rst_mem_ready", 32'(mem_ready), 1);
        check_eq("rst_eng_ready", 32'(eng_ready), 0);
        check_eq("rst_bcast_valid", 32'(bcast_valid), 0);
        check_eq("rst_bcast_lit", 32'(bcast_lit), 0);
        check_eq("rst_conflict", 32'(conflict), 0);
        check_eq("rst_conflict_var", 32'(conflict_var), 0);
        check_eq("rst_q_count", 32'(q_count), 0);
        step();
        rst = 1'b1;
        step();

        // Load 3, -5 with mem_done alongside the last literal.
        mem_valid = 1'b1; mem_lit = 8'd3; #1;
        check_eq("load_mem_ready", 32'(mem_ready), 1);
        step();
        mem_lit = 8'hFB; mem_done = 1'b1; bcast_ready = 1'b1; #1;
        check_eq("load_bv1", 32'(bcast_valid), 1);
        check_eq("load_bl1", 32'(bcast_lit), 'h03);
        check_eq("load_cnt1", 32'(q_count), 1);
        step();
        mem_valid = 1'b0; mem_done = 1'b0; #1;
        check_eq("load_bl2", 32'(bcast_lit), 'hFB);
        check_eq("load_cnt2", 32'(q_count), 1);
        check_eq("run_mem_ready", 32'(mem_ready), 0);
        step();
        check_eq("load_cnt_drain", 32'(q_count), 0);
        check_eq("load_bv_drain", 32'(bcast_valid), 0);

        // Round-robin: all four request, then engines 0 and 3.
        eng_lit = {8'd6, 8'd4, 8'd2, 8'd1};
        eng_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) eng_valid = 4'b1001;
            #1;
            check_eq($sformatf("rr_gnt%0d", i), 32'(eng_ready), 32'(rr_exp[i]));
            check_eq($sformatf("rr_bv%0d", i), 32'(bcast_valid), 32'(bv_exp[i]));
            if (bv_exp[i]) check_eq($sformatf("rr_bl%0d", i), 32'(bcast_lit), 32'(bl_exp[i]));
            step();
        end
        eng_valid = '0;
        step();
        check_eq("rr_cnt_end", 32'(q_count), 0);

        // Duplicate: load 7, engine 2 sends 7.
        clear = 1'b1; step();
        clear = 1'b0; mem_valid = 1'b1; mem_lit = 8'd7; mem_done = 1'b1; bcast_ready = 1'b0; #1;
        check_eq("dup_mem_ready", 32'(mem_ready), 1);
        step();
        mem_valid = 1'b0; mem_done = 1'b0;
        eng_lit = {8'd0, 8'd7, 8'd0, 8'd0}; eng_valid = 4'b0100; #1;
        check_eq("dup_gnt", 32'(eng_ready), 'b0100);
        check_eq("dup_cnt_before", 32'(q_count), 1);
        step();
        eng_valid = '0; #1;
        check_eq("dup_cnt_after", 32'(q_count), 1);
        check_eq("dup_head", 32'(bcast_lit), 'h07);
`ifdef UCA_STATS_EN
        check_eq("dup_stat_dup", 32'(stat_dup), 1);
        check_eq("dup_stat_push", 32'(stat_push), 1);
`endif

        // Conflict: load 9, engine 1 sends -9.
        clear = 1'b1; step();
        clear = 1'b0; mem_valid = 1'b1; mem_lit = 8'd9; mem_done = 1'b1; step();
        mem_valid = 1'b0; mem_done = 1'b0;
        eng_lit = {8'd0, 8'd0, 8'hF7, 8'd0}; eng_valid = 4'b0010; #1;
        check_eq("conf_gnt", 32'(eng_ready), 'b0010);
        check_eq("conf_pre_flag", 32'(conflict), 0);
        step();
        check_eq("conf_flag", 32'(conflict), 1);
        check_eq("conf_var", 32'(conflict_var), 9);
        check_eq("conf_bv", 32'(bcast_valid), 0);
        check_eq("conf_cnt", 32'(q_count), 0);
        eng_valid = 4'b1111; mem_valid = 1'b1; bcast_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check_eq("conf_hold_flag", 32'(conflict), 1);
        check_eq("conf_hold_eng", 32'(eng_ready), 0);
        check_eq("conf_hold_mem", 32'(mem_ready), 0);
        check_eq("conf_hold_var", 32'(conflict_var), 9);
        eng_valid = '0; mem_valid = 1'b0; bcast_ready = 1'b0;
        clear = 1'b1; step();
        clear = 1'b0; #1;
        check_eq("clr_flag", 32'(conflict), 0);
        check_eq("clr_var", 32'(conflict_var), 0);
        check_eq("clr_mem_ready", 32'(mem_ready), 1);

        // Full FIFO: 16 pushes with no pop, then stall, then pop+grant together.
        mem_done = 1'b1; step();
        mem_done = 1'b0;
        eng_valid = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            eng_lit = 32'(i + 1);
            step();
        end
        eng_lit = 32'd17; #1;
        check_eq("full_cnt", 32'(q_count), 16);
        check_eq("full_no_gnt", 32'(eng_ready), 0);
        step();
        check_eq("full_cnt_hold", 32'(q_count), 16);
        check_eq("full_head", 32'(bcast_lit), 1);
        bcast_ready = 1'b1; #1;
        check_eq("full_popgnt", 32'(eng_ready), 'b0001);
        step();
        eng_valid = '0; bcast_ready = 1'b0; #1;
        check_eq("full_cnt_swap", 32'(q_count), 16);
        check_eq("full_head2", 32'(bcast_lit), 2);
`ifdef UCA_STATS_EN
        check_eq("full_stat_stall", 32'(stat_stall), 1);
`endif

        // Async reset mid-RUN with 5 queued.
        clear = 1'b1; step();
        clear = 1'b0; mem_done = 1'b1; step();
        mem_done = 1'b0; eng_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            eng_lit = 32'(20 + i);
            step();
        end
        eng_lit = 32'd25; #1;
        check_eq("ar_cnt", 32'(q_count), 5);
        check_eq("ar_gnt_pre", 32'(eng_ready), 'b0001);
        #1 rst = 1'b0;
        #1;
        check_eq("ar_eng_ready", 32'(eng_ready), 0);
        check_eq("ar_mem_ready", 32'(mem_ready), 1);
        check_eq("ar_cnt0", 32'(q_count), 0);
        check_eq("ar_bv", 32'(bcast_valid), 0);
        eng_valid = '0;
        step(); step();
        rst = 1'b1;
        mem_valid = 1'b1; mem_lit = 8'd20; #1;
        check_eq("ar_reload_ready", 32'(mem_ready), 1);
        step();
        check_eq("ar_tbl_clear", 32'(q_count), 1);
        mem_lit = 8'd9; step();
        check_eq("ar_cnt2", 32'(q_count), 2);
        mem_lit = 8'hF7; step();
        mem_valid = 1'b0; #1;
        check_eq("ar_conf", 32'(conflict), 1);
        check_eq("ar_conf_var", 32'(conflict_var), 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
